// File: rtl/clkgen_pkg.sv
// Shared types and constants for the CPU clock sequencer and its PLL reconfiguration FSM.
package clkgen_pkg;

    typedef enum logic [1:0] {
        PLL_IDLE  = 2'd0,
        PLL_DELAY = 2'd1,
        PLL_STEP  = 2'd2,
        PLL_WAIT  = 2'd3
    } pll_fsm_t;

    localparam int DEF_RECONF_DELAY = 8;
    localparam int DEF_SRDY_TIMEOUT = 4096;

    localparam int SPEED_3M5 = 0;
    localparam int SPEED_7M  = 1;
    localparam int SPEED_14M = 2;

endpackage

// File: rtl/pll_reconf_sequencer.sv
// PLL reconfiguration FSM: debounce an option change, issue one SSTEP pulse, then wait for
// ready or time out.
module pll_reconf_sequencer
    import clkgen_pkg::*;
#(
    parameter int OPTW         = 3,
    parameter int RECONF_DELAY = DEF_RECONF_DELAY,
    parameter int SRDY_TIMEOUT = DEF_SRDY_TIMEOUT
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [OPTW-1:0] i_option,
    input  logic            i_srdy,
    output logic [OPTW-1:0] o_state,
    output logic            o_sstep,
    output logic            o_busy,
    output pll_fsm_t        o_fsm
);

    localparam int TMAX = (RECONF_DELAY > SRDY_TIMEOUT) ? RECONF_DELAY : SRDY_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] T_RECONF = TW'(RECONF_DELAY);
    localparam logic [TW-1:0] T_SRDY   = TW'(SRDY_TIMEOUT);

    pll_fsm_t        r_fsm;
    logic [TW-1:0]   r_timer;
    logic [OPTW-1:0] r_state;

    pll_fsm_t        w_fsm_nxt;
    logic [TW-1:0]   w_timer_nxt;
    logic [OPTW-1:0] w_state_nxt;
    logic            w_change;

    assign w_change = (i_option != r_state);

    // Reset lands in DELAY so the PLL is always reconfigured once at boot.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fsm   <= PLL_DELAY;
            r_timer <= T_RECONF;
            r_state <= '0;
        end else begin
            r_fsm   <= w_fsm_nxt;
            r_timer <= w_timer_nxt;
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_timer_nxt = r_timer;
        w_state_nxt = r_state;
        case (r_fsm)
            PLL_IDLE: begin
                if (w_change) begin
                    w_state_nxt = i_option;
                    w_timer_nxt = T_RECONF;
                    w_fsm_nxt   = PLL_DELAY;
                end
            end
            PLL_DELAY: begin
                if (w_change) begin
                    w_state_nxt = i_option;
                    w_timer_nxt = T_RECONF;
                end else if (r_timer == '0) begin
                    w_fsm_nxt = PLL_STEP;
                end else begin
                    w_timer_nxt = r_timer - TW'(1);
                end
            end
            PLL_STEP: begin
                w_timer_nxt = T_SRDY;
                w_fsm_nxt   = PLL_WAIT;
            end
            PLL_WAIT: begin
                // Option changes here are left for IDLE to pick up on its next cycle.
                if (i_srdy || (r_timer == '0)) begin
                    w_fsm_nxt = PLL_IDLE;
                end else begin
                    w_timer_nxt = r_timer - TW'(1);
                end
            end
            default: w_fsm_nxt = PLL_IDLE;
        endcase
    end

    always_comb begin
        o_sstep = (r_fsm == PLL_STEP);
        o_busy  = !((r_fsm == PLL_IDLE) && !w_change);
        o_state = r_state;
        o_fsm   = r_fsm;
    end

endmodule

// File: rtl/cpu_clock_sequencer.sv
// CPU clock-enable generator with a glitch-free turbo ladder and contention stretching,
// plus the PLL reconfiguration sequencer.
module cpu_clock_sequencer
    import clkgen_pkg::*;
#(
    parameter int NSPEEDS      = 3,
    parameter int OPTW         = 3,
    parameter int RECONF_DELAY = DEF_RECONF_DELAY,
    parameter int SRDY_TIMEOUT = DEF_SRDY_TIMEOUT,
    localparam int SW          = (NSPEEDS > 1) ? $clog2(NSPEEDS) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SW-1:0]   turbo_sel,
    input  logic            contention,
    input  logic [OPTW-1:0] pll_option,
    input  logic            pll_srdy,
    output logic            cpu_ce_rise,
    output logic            cpu_ce_fall,
    output logic            cpuclk,
    output logic            cpuclkplain,
    output logic [SW-1:0]   speed_cur,
    output logic [OPTW-1:0] pll_state,
    output logic            pll_sstep,
    output logic            pll_busy,
    output pll_fsm_t        pll_fsm_dbg
);

    logic [NSPEEDS-1:0] r_cnt;
    logic [SW-1:0]      r_speed;
    logic               r_cpuclk;
    logic               r_plain;
    logic               r_ce_rise;
    logic               r_ce_fall;

    logic [SW-1:0]      w_shamt;
    logic [NSPEEDS-1:0] w_half;
    logic [NSPEEDS-1:0] w_mask;
    logic [NSPEEDS-1:0] w_phase;
    logic               w_rise_slot;
    logic               w_fall_slot;
    logic               w_do_rise;
    logic               w_do_fall;
    logic [SW-1:0]      w_sel_sat;

    // Half period is 2^(k-1) with k = NSPEEDS-speed; the mask wraps to all-ones at k = NSPEEDS.
    assign w_shamt     = SW'(NSPEEDS - 1) - r_speed;
    assign w_half      = NSPEEDS'(1) << w_shamt;
    assign w_mask      = (w_half << 1) - NSPEEDS'(1);
    assign w_phase     = r_cnt & w_mask;
    assign w_rise_slot = (w_phase == '0);
    assign w_fall_slot = (w_phase == w_half);
    assign w_do_rise   = w_rise_slot && !r_cpuclk;
    assign w_do_fall   = w_fall_slot && !contention;
    assign w_sel_sat   = ({1'b0, turbo_sel} >= (SW + 1)'(NSPEEDS)) ? SW'(NSPEEDS - 1) : turbo_sel;

    // cnt==0 is a rise slot at every speed, so switching there never creates a runt phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_speed   <= '0;
            r_cpuclk  <= 1'b0;
            r_plain   <= 1'b0;
            r_ce_rise <= 1'b0;
            r_ce_fall <= 1'b0;
        end else begin
            r_cnt     <= r_cnt + NSPEEDS'(1);
            r_ce_rise <= w_do_rise;
            r_ce_fall <= w_do_fall;
            if (r_cnt == '0) begin
                r_speed <= w_sel_sat;
            end
            if (w_do_rise) begin
                r_cpuclk <= 1'b1;
            end else if (w_do_fall) begin
                r_cpuclk <= 1'b0;
            end
            if (w_rise_slot) begin
                r_plain <= 1'b1;
            end else if (w_fall_slot) begin
                r_plain <= 1'b0;
            end
        end
    end

    assign cpu_ce_rise = r_ce_rise;
    assign cpu_ce_fall = r_ce_fall;
    assign cpuclk      = r_cpuclk;
    assign cpuclkplain = r_plain;
    assign speed_cur   = r_speed;

    pll_reconf_sequencer #(
        .OPTW         (OPTW),
        .RECONF_DELAY (RECONF_DELAY),
        .SRDY_TIMEOUT (SRDY_TIMEOUT)
    ) u_pll_seq (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_option (pll_option),
        .i_srdy   (pll_srdy),
        .o_state  (pll_state),
        .o_sstep  (pll_sstep),
        .o_busy   (pll_busy),
        .o_fsm    (pll_fsm_dbg)
    );

endmodule
